demultiplexer_stream_8: RTL

DEMULTIPLEXER_STREAM_8 -- requirements
Module: demultiplexer_stream_8

---
 rtl/demultiplexer_stream_8_pkg.sv | 23 ++
 rtl/demux_channel_slot.sv | 47 ++++
 rtl/demultiplexer_stream_8.sv | 88 ++++++++
 3 files changed

// File: rtl/demultiplexer_stream_8_pkg.sv
// Shared constants for the 8-way stream demultiplexer: channel count,
// select and drop-counter widths, channel-state encoding and the select decoder.
package demultiplexer_stream_8_pkg;

   localparam int NrOfChannels = 8;
   localparam int SelWidth     = 3;
   localparam int DroppedWidth = 16;

   // Channel-slot states: a slot is either empty or holding one word.
   localparam logic ChanEmpty = 1'b0;
   localparam logic ChanFull  = 1'b1;

   localparam logic [DroppedWidth-1:0] DroppedMax = '1;

   // Turns a channel index into a one-hot channel mask.
   function automatic logic [NrOfChannels-1:0] selToOneHot(input logic [SelWidth-1:0] sel);
      logic [NrOfChannels-1:0] oneHot;
      oneHot      = '0;
      oneHot[sel] = 1'b1;
      return oneHot;
   endfunction

endpackage

// File: rtl/demux_channel_slot.sv
// One output channel of the demultiplexer: a single-word holding register
// with its valid flag. A fill always wins over a drain, which gives the
// drain-and-refill-in-one-cycle behaviour with no bubble.
module demux_channel_slot
   import demultiplexer_stream_8_pkg::*;
#(
   parameter int NrOfBits = 32
) (
   input  logic                Clock,
   input  logic                Reset_n,
   input  logic                Fill_i,
   input  logic [NrOfBits-1:0] Data_i,
   input  logic                Ready_i,
   output logic                Valid_o,
   output logic [NrOfBits-1:0] Data_o
);

   logic                state_q, state_d;
   logic [NrOfBits-1:0] data_q, data_d;

   // Next-state: fill loads the word and marks FULL; a drain without fill empties; data holds otherwise.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      if (Fill_i) begin
         state_d = ChanFull;
         data_d  = Data_i;
      end else if ((state_q == ChanFull) && Ready_i) begin
         state_d = ChanEmpty;
      end
   end

   // Slot registers, cleared asynchronously so reset discards any held word.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ChanEmpty;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   assign Valid_o = (state_q == ChanFull);
   assign Data_o  = data_q;

endmodule

// File: rtl/demultiplexer_stream_8.sv
// Ready/valid stream demultiplexer: routes each accepted input word to one
// of eight independently drained output slots chosen by Sel, and counts
// input words offered while the block is disabled.
module demultiplexer_stream_8
   import demultiplexer_stream_8_pkg::*;
#(
   parameter int NrOfBits = 32
) (
   input  logic                    Clock,
   input  logic                    Reset_n,
   input  logic                    Enable,
   input  logic                    InValid,
   output logic                    InReady,
   input  logic [SelWidth-1:0]     Sel,
   input  logic [NrOfBits-1:0]     DemuxIn,
   output logic [NrOfChannels-1:0] OutValid,
   input  logic [NrOfChannels-1:0] OutReady,
   output logic [NrOfBits-1:0]     DemuxOut_0,
   output logic [NrOfBits-1:0]     DemuxOut_1,
   output logic [NrOfBits-1:0]     DemuxOut_2,
   output logic [NrOfBits-1:0]     DemuxOut_3,
   output logic [NrOfBits-1:0]     DemuxOut_4,
   output logic [NrOfBits-1:0]     DemuxOut_5,
   output logic [NrOfBits-1:0]     DemuxOut_6,
   output logic [NrOfBits-1:0]     DemuxOut_7,
   output logic [DroppedWidth-1:0] Dropped
);

   logic                                   transfer;
   logic [NrOfChannels-1:0]                fillVec;
   logic [NrOfChannels-1:0][NrOfBits-1:0]  chanData;
   logic [DroppedWidth-1:0]                dropped_q, dropped_d;

   // The addressed slot can take a word if it is empty or is being drained on this same edge.
   assign InReady  = Enable & (~OutValid[Sel] | OutReady[Sel]);
   assign transfer = InValid & InReady;

   // Only the addressed slot is filled, and only on an actual transfer.
   always_comb begin
      fillVec = '0;
      if (transfer) begin
         fillVec = selToOneHot(Sel);
      end
   end

   for (genvar k = 0; k < NrOfChannels; k++) begin : gSlot
      demux_channel_slot #(
         .NrOfBits (NrOfBits)
      ) uSlot (
         .Clock   (Clock),
         .Reset_n (Reset_n),
         .Fill_i  (fillVec[k]),
         .Data_i  (DemuxIn),
         .Ready_i (OutReady[k]),
         .Valid_o (OutValid[k]),
         .Data_o  (chanData[k])
      );
   end

   assign DemuxOut_0 = chanData[0];
   assign DemuxOut_1 = chanData[1];
   assign DemuxOut_2 = chanData[2];
   assign DemuxOut_3 = chanData[3];
   assign DemuxOut_4 = chanData[4];
   assign DemuxOut_5 = chanData[5];
   assign DemuxOut_6 = chanData[6];
   assign DemuxOut_7 = chanData[7];

   // Drop counter: counts offered-but-disabled cycles and sticks at all-ones instead of wrapping.
   always_comb begin
      dropped_d = dropped_q;
      if (InValid && !Enable && (dropped_q != DroppedMax)) begin
         dropped_d = dropped_q + DroppedWidth'(1);
      end
   end

   // Drop counter register.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         dropped_q <= '0;
      end else begin
         dropped_q <= dropped_d;
      end
   end

   assign Dropped = dropped_q;

endmodule
